// File: rtl/a2d_intf_if.sv
// rtl/a2d_intf_if.sv - conversion request/result and SPI pins between motion_cntrl, a2d_intf and the ADC.
interface a2d_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport slave (
        input  strt_cnv,
        input  chnnl,
        input  MISO,
        output cnv_cmplt,
        output res,
        output SS_n,
        output SCLK,
        output MOSI
    );

    modport master (
        output strt_cnv,
        output chnnl,
        output MISO,
        input  cnv_cmplt,
        input  res,
        input  SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - two-frame SPI conversion engine for an ADC128S-class converter.
// Frame 1 sends the channel command; frame 2 repeats it and captures the 12-bit result.
module a2d_intf #(
    parameter int FRAME_GAP = 32
) (
    input  logic        clk,
    input  logic        rst,
    a2d_intf_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, FRAME1, GAP, FRAME2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  div_q, div_d;
    logic [4:0]  fall_cnt_q, fall_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic [15:0] tx_q, tx_d;
    logic [11:0] rx_q, rx_d;
    logic        ss_n_q, ss_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cmplt_q, cmplt_d;
    logic [11:0] res_q, res_d;
    logic        in_frame;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        fall_cnt_d = fall_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        chnnl_d    = chnnl_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cmplt_d    = cmplt_q;
        res_d      = res_q;
        in_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.strt_cnv) begin
                    chnnl_d    = bus.chnnl;
                    tx_d       = {2'b00, bus.chnnl, 11'h000};
                    div_d      = 5'b10111;
                    fall_cnt_d = 5'd0;
                    cmplt_d    = 1'b0;
                    state_d    = FRAME1;
                end
            end
            FRAME1, FRAME2: begin
                div_d = div_q + 5'd1;
                if (div_q == 5'b01111) begin
                    rx_d = {rx_q[10:0], bus.MISO};
                end
                if (div_q == 5'b11111) begin
                    // The 17th fall is never driven: it closes the frame instead.
                    if (fall_cnt_q == 5'd16) begin
                        if (state_q == FRAME1) begin
                            tx_d      = {2'b00, chnnl_q, 11'h000};
                            gap_cnt_d = 16'd0;
                            state_d   = GAP;
                        end else begin
                            res_d   = rx_q;
                            cmplt_d = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        fall_cnt_d = fall_cnt_q + 5'd1;
                        // Bit 15 is already on MOSI from frame start, so the first fall keeps it.
                        if (fall_cnt_q != 5'd0) begin
                            tx_d = {tx_q[14:0], 1'b0};
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_cnt_q == 16'(FRAME_GAP - 1)) begin
                    div_d      = 5'b10111;
                    fall_cnt_d = 5'd0;
                    state_d    = FRAME2;
                end
            end
            default: state_d = IDLE;
        endcase

        in_frame = (state_d == FRAME1) || (state_d == FRAME2);
        ss_n_d   = !in_frame;
        sclk_d   = in_frame ? div_d[4] : 1'b1;
        mosi_d   = in_frame ? tx_d[15] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= 5'd0;
            fall_cnt_q <= 5'd0;
            gap_cnt_q  <= 16'd0;
            chnnl_q    <= 3'd0;
            tx_q       <= 16'h0000;
            rx_q       <= 12'h000;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            cmplt_q    <= 1'b0;
            res_q      <= 12'h000;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            fall_cnt_q <= fall_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            chnnl_q    <= chnnl_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cmplt_q    <= cmplt_d;
            res_q      <= res_d;
        end
    end

    assign bus.SS_n      = ss_n_q;
    assign bus.SCLK      = sclk_q;
    assign bus.MOSI      = mosi_q;
    assign bus.cnv_cmplt = cmplt_q;
    assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// tb/tb_a2d_intf.sv - scoreboard bench for a2d_intf with a behavioural ADC128S model.
module tb_a2d_intf;

    localparam int GAP = 32;

    typedef struct {
        logic [15:0] cmd;
        logic [11:0] res;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    logic [15:0] adc_word = 16'h0000;
    logic [15:0] adc_sr   = 16'h0000;

    a2d_intf_if bus();

    a2d_intf #(.FRAME_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ADC model: loads its word as SS_n falls, advances after each SCLK rise.
    always @(negedge bus.SS_n) adc_sr = adc_word;
    always @(posedge bus.SCLK) if (!bus.SS_n) adc_sr = adc_sr << 1;
    assign bus.MISO = adc_sr[15];

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_cmplt = 1'b0;
    logic [15:0] mosi_sr = 16'h0;
    int          rise_cnt = 0, total_rise = 0, frame_idx = 0;
    int          fall_cyc = 0, rise_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            frame_idx  = 0;
            rise_cnt   = 0;
            total_rise = 0;
        end else begin
            if (prev_sclk == 1'b0 && bus.SCLK == 1'b1) begin
                mosi_sr = {mosi_sr[14:0], bus.MOSI};
                rise_cnt++;
                total_rise++;
            end
            if (prev_ss == 1'b1 && bus.SS_n == 1'b0) begin
                if (frame_idx == 0) begin
                    total_rise = 0;
                    if (exp_q.size() != 0) chk("frame1_start", cyc, exp_q[0].t0);
                end else begin
                    chk("frame_gap", cyc - rise_cyc, GAP);
                end
                fall_cyc = cyc;
                mosi_sr  = 16'h0;
                rise_cnt = 0;
            end
            if (prev_ss == 1'b0 && bus.SS_n == 1'b1) begin
                if (exp_q.size() != 0) begin
                    chk("mosi_cmd", mosi_sr, exp_q[0].cmd);
                    chk("frame_rises", rise_cnt, 16);
                    chk("ss_low_len", cyc - fall_cyc, 521);
                end
                rise_cyc = cyc;
                frame_idx++;
            end
            if (prev_cmplt == 1'b0 && bus.cnv_cmplt == 1'b1) begin
                chk("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("res", bus.res, exp_q[0].res);
                    chk("done_time", cyc, exp_q[0].t0 + 1074);
                    chk("total_rises", total_rise, 32);
                    chk("frames_before_done", frame_idx, 2);
                    void'(exp_q.pop_front());
                end
                frame_idx  = 0;
                total_rise = 0;
            end
        end
        prev_ss    = bus.SS_n;
        prev_sclk  = bus.SCLK;
        prev_cmplt = bus.cnv_cmplt;
    end

    // Stimulus (always entered and left on a negedge)
    int last_t0 = 0;

    task automatic start(input logic [2:0] ch, input logic [15:0] cmd,
                         input logic [15:0] word, input logic [11:0] r);
        exp_t e;
        adc_word     = word;
        bus.strt_cnv = 1'b1;
        bus.chnnl    = ch;
        last_t0      = cyc + 1;
        e.cmd = cmd; e.res = r; e.t0 = last_t0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        chk("cmplt_cleared_on_start", bus.cnv_cmplt, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.cnv_cmplt && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", bus.cnv_cmplt, 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    logic [15:0] loop_word [6] = '{16'h0001, 16'hF234, 16'h0FFF, 16'h0800, 16'h5A5A, 16'h0321};
    logic [11:0] loop_res  [6] = '{12'h001, 12'h234, 12'hFFF, 12'h800, 12'hA5A, 12'h321};
    logic [15:0] loop_cmd  [6] = '{16'h0000, 16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2800};

    initial begin
        int bad;
        int t0;
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'd0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", bus.SS_n, 1);
        chk("rst_sclk", bus.SCLK, 1);
        chk("rst_mosi", bus.MOSI, 0);
        chk("rst_cmplt", bus.cnv_cmplt, 0);
        chk("rst_res", bus.res, 0);
        rst = 1'b0;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (bus.SS_n !== 1'b1 || bus.SCLK !== 1'b1 || bus.MOSI !== 1'b0 || bus.cnv_cmplt !== 1'b0)
                bad++;
        end
        chk("idle_quiet", bad, 0);

        start(3'd3, 16'h1800, 16'h0ABC, 12'hABC);
        wait_done();

        chk("cmplt_held_before_start", bus.cnv_cmplt, 1);
        start(3'd7, 16'h3800, 16'hFFFF, 12'hFFF);
        wait_done();

        start(3'd2, 16'h1000, 16'h0555, 12'h555);
        t0 = last_t0;
        wait_cyc(t0 + 99);
        bus.strt_cnv = 1'b1; bus.chnnl = 3'd5;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        wait_cyc(t0 + 599);
        bus.strt_cnv = 1'b1; bus.chnnl = 3'd5;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        chk("ignored_strt_ss_low", bus.SS_n, 0);

        // strt_cnv held across the completing edge: only the following edge accepts it.
        wait_cyc(t0 + 1073);
        begin
            exp_t e;
            adc_word = 16'h0CDE;
            bus.strt_cnv = 1'b1; bus.chnnl = 3'd5;
            e.cmd = 16'h2800; e.res = 12'hCDE; e.t0 = t0 + 1075;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("b2b_not_taken", bus.cnv_cmplt, 1);
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        chk("b2b_cleared", bus.cnv_cmplt, 0);
        last_t0 = t0 + 1075;
        wait_done();

        start(3'd1, 16'h0800, 16'h0777, 12'h777);
        t0 = last_t0;
        wait_cyc(t0 + 299);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ss_n", bus.SS_n, 1);
        chk("async_rst_sclk", bus.SCLK, 1);
        chk("async_rst_mosi", bus.MOSI, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_res_zero", bus.res, 0);
        repeat (1000) @(negedge clk);
        chk("aborted_res_kept", bus.res, 0);
        chk("aborted_no_cmplt", bus.cnv_cmplt, 0);

        start(3'd4, 16'h2000, 16'h0246, 12'h246);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            start(3'(i), loop_cmd[i], loop_word[i], loop_res[i]);
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a2d_intf.md
# a2d_intf

SPI-side analog-to-digital conversion interface that answers the conversion requests issued by `motion_cntrl`. It accepts a single-cycle `strt_cnv` with a 3-bit channel select and runs two 16-bit SPI frames to an external ADC128S-class converter. The first frame sends the channel command; the second frame repeats the command and reads the 12-bit result. When the result is available, the block returns it on `res` and raises `cnv_cmplt`.

## Interface
Parameters:
- `FRAME_GAP`, default 32: number of clk cycles `SS_n` is held high between frame 1 and frame 2.

Ports:
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `strt_cnv`  input  1  conversion request; sampled only in IDLE.
- `chnnl`  input  3  ADC channel; latched on an accepted `strt_cnv`.
- `cnv_cmplt`  output  1  result valid; level signal.
- `res`  output  12  conversion result.
- `SS_n`  output  1  SPI slave select, active low.
- `SCLK`  output  1  SPI clock, clk/32; idles high.
- `MOSI`  output  1  SPI data to the ADC.
- `MISO`  input  1  SPI data from the ADC.

## Operation
- States:
  - IDLE
  - FRAME1
  - GAP
  - FRAME2
- Reset values:
  - `SS_n`=1, `SCLK`=1, `MOSI`=0
  - `cnv_cmplt`=0, `res`=12'h000
  - state = IDLE
- IDLE → FRAME1 when `strt_cnv`=1 at a clk edge:
  - Latch `chnnl`.
  - Load the TX shifter with {2'b00, chnnl, 11'h000}.
  - Preset the 5-bit divider `div` to 5'b10111.
  - Clear `cnv_cmplt`.
- SCLK generation:
  - `SCLK` = `div[4]` while in FRAME1 or FRAME2; otherwise `SCLK` is 1.
  - `div` increments every clk in the frame states.
- MOSI:
  - `MOSI` = TX shifter MSB while `SS_n`=0; otherwise 0.
  - The TX shifter shifts left (zero fill) on each SCLK falling edge, i.e. the cycle `div` goes 11111 → 00000.
- MISO:
  - `MISO` is shifted into a 16-bit RX shifter (LSB in) on each SCLK rising edge, i.e. the cycle `div` goes 01111 → 10000.
- Frame length:
  - Each frame ends at the point where the 17th SCLK fall would occur.
  - `SS_n` rises at that edge and `SCLK` stays high.
  - Each frame therefore has exactly 16 SCLK falls and 16 SCLK rises.
- FRAME1 → GAP at frame end:
  - Reload the TX shifter with the same command word.
- GAP → FRAME2 after `FRAME_GAP` cycles:
  - Preset `div` to 5'b10111 again.
- FRAME2 → IDLE at frame end:
  - `res` ← RX[11:0].
  - `cnv_cmplt` ← 1.
- `cnv_cmplt` stays 1 until the next accepted `strt_cnv`, which clears it in the same edge the new conversion starts.
- `res` holds its value until the next completion.
- `strt_cnv` outside IDLE is ignored: no restart and no queuing.
- `chnnl` changes after acceptance have no effect.
- `rst` asserted mid-frame:
  - Immediately returns all outputs to their reset values.
  - Any partial result is discarded; `res` does not update.

## Timing
- Let t0 be the clk edge that accepts `strt_cnv`.
- Frame 1:
  - `SS_n` falls at t0.
  - First SCLK fall at t0+9; first SCLK rise at t0+25.
  - Falls at t0+9+32k and rises at t0+25+32k, for k = 0..15.
  - `SS_n` rises at t0+521, so `SS_n` is low for 521 cycles.
- Frame 2:
  - `SS_n` falls at t0+521+`FRAME_GAP` (t0+553 with the default).
  - Same internal timing as frame 1.
- Completion:
  - `cnv_cmplt` and `res` update at t0+1074 (default), in the same edge `SS_n` rises.
- Back-to-back:
  - `strt_cnv` at t0+1074 is not accepted, since the state is still FRAME2 during that edge.
  - The earliest accepted restart is t0+1075.
- MOSI timing:
  - MOSI bit 15 is valid from t0.
  - Each later bit changes one cycle after an SCLK fall is decoded, i.e. coincident with SCLK going low.
  - Each bit is stable for 16 cycles before the SCLK rise.

## Test plan
- Reset check:
  - Stimulus: assert `rst` for 3 cycles.
  - Required: `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `res`=0; with `strt_cnv`=0 nothing toggles for 2000 cycles.
- Channel 3, ADC model returning 16'h0ABC in frame 2:
  - Required: MOSI captured on SCLK rises in both frames = 16'h1800.
  - Required: exactly 32 SCLK rises in total.
  - Required: `cnv_cmplt` rises at t0+1074 with `res`=12'hABC.
- Channel 7, ADC model returning 16'hFFFF:
  - Required: command = 16'h3800.
  - Required: `res`=12'hFFF; the upper 4 MISO bits are ignored.
  - Required: `cnv_cmplt` cleared exactly at the next accepted `strt_cnv`.
- `strt_cnv` pulsed at t0+100 and t0+600 with `chnnl` changed to 5:
  - Required: no restart, and frame 2 still sends the originally latched channel.
  - Required: completion at t0+1074.
- `rst` asserted at t0+300:
  - Required: `SS_n`=1 and `SCLK`=1 asynchronously; `res` keeps 0.
  - Required: a new `strt_cnv` after release completes normally with correct timing.
- Loop of 6 conversions driven like `motion_cntrl` (channels 0..5, `strt_cnv` on completion):
  - Required: each `res` matches the model value for its channel.
  - Required: `SS_n` high gap between frames is exactly `FRAME_GAP`.
